cpmg_pulse_sched: RTL

- Sequences the transmitter H-bridge state machine for a CPMG NMR echo train: one 90° excitation, then N refocusing 180° pulses separated by 2·tau.
- Produces the 5-bit bridge control word `bri_i` (bit meaning below) and an echo acquisition window for the receiver/ADC path.
- All timing counts in `clk_4f_en` ticks on the `clk_dds` domain, so pulse edges line up with bridge state updates.
- Sits between the register/config block (software-loaded lengths) and the bridge driver.

---
 rtl/cpmg_pulse_sched.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cpmg_pulse_sched.sv
// cpmg_pulse_sched: CPMG echo-train sequencer for the transmitter H-bridge.
// Generates the 5-bit bridge control word bri_i, the echo acquisition window
// and the echo counter. All durations count clk_4f_en ticks on clk_dds.
// Optional build macro CPMG_PHASE_ALT_EN: alternate the 180-degree phase bit
// on every refocusing pulse (ph180 XOR k[0]).
module cpmg_pulse_sched #(
    parameter int CNT_W  = 16,
    parameter int ECHO_W = 12
) (
    input  logic              clk_dds,
    input  logic              rst,
    input  logic              clk_4f_en,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  t90_len,
    input  logic [CNT_W-1:0]  t180_len,
    input  logic [CNT_W-1:0]  tau_len,
    input  logic [ECHO_W-1:0] echo_num,
    input  logic              ph90,
    input  logic              ph180,
    input  logic              full_freq,
    input  logic              fast90,
    output logic [4:0]        bri_i,
    output logic              busy,
    output logic              done,
    output logic              echo_win,
    output logic [ECHO_W-1:0] echo_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_P90, S_TAU1, S_P180, S_ECHO, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W:0]      cnt, cnt_nxt;
    logic [4:0]          bri_nxt;
    logic                busy_nxt, done_nxt, win_nxt;
    logic [ECHO_W-1:0]   ecnt_nxt;

    // Shadow copies of the configuration, frozen for the whole sequence
    logic [CNT_W-1:0]    t90_s, t180_s, tau_s;
    logic [ECHO_W-1:0]   echo_num_s;
    logic                ph90_s, ph180_s, ff_s, f90_s;

    logic                accept;
    logic                last;
    logic [CNT_W-1:0]    t90_e, t180_e, tau_e;
    logic [ECHO_W-1:0]   ecnt_inc;
    logic                ph_first, ph_next;

    assign accept = (state == S_IDLE) && start && !abort;
    assign last   = (cnt == {{CNT_W{1'b0}}, 1'b1});

    // Zero lengths behave as a single tick
    assign t90_e  = (t90_s  == '0) ? CNT_W'(1) : t90_s;
    assign t180_e = (t180_s == '0) ? CNT_W'(1) : t180_s;
    assign tau_e  = (tau_s  == '0) ? CNT_W'(1) : tau_s;

    assign ecnt_inc = echo_cnt + ECHO_W'(1);

`ifdef CPMG_PHASE_ALT_EN
    // The k-th refocusing pulse follows k completed echoes, so k[0] is the
    // low bit of the echo count at P180 entry.
    assign ph_first = ph180_s;
    assign ph_next  = ph180_s ^ ecnt_inc[0];
`else
    assign ph_first = ph180_s;
    assign ph_next  = ph180_s;
`endif

    // Capture configuration when a sequence is accepted
    always_ff @(posedge clk_dds or posedge rst) begin
        if (rst) begin
            t90_s      <= '0;
            t180_s     <= '0;
            tau_s      <= '0;
            echo_num_s <= '0;
            ph90_s     <= 1'b0;
            ph180_s    <= 1'b0;
            ff_s       <= 1'b0;
            f90_s      <= 1'b0;
        end else if (accept) begin
            t90_s      <= t90_len;
            t180_s     <= t180_len;
            tau_s      <= tau_len;
            echo_num_s <= echo_num;
            ph90_s     <= ph90;
            ph180_s    <= ph180;
            ff_s       <= full_freq;
            f90_s      <= fast90;
        end
    end

    // State, duration counter and registered outputs
    always_ff @(posedge clk_dds or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bri_i    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            echo_win <= 1'b0;
            echo_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bri_i    <= bri_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            echo_win <= win_nxt;
            echo_cnt <= ecnt_nxt;
        end
    end

    // Next-state and next-output logic; timed states advance only on ticks
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bri_nxt   = bri_i;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        win_nxt   = echo_win;
        ecnt_nxt  = echo_cnt;

        if (state != S_IDLE && abort) begin
            // Abort drops the bridge at once; echo_cnt is kept for readback
            state_nxt = S_IDLE;
            bri_nxt   = '0;
            win_nxt   = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_nxt = S_ARM;
                        busy_nxt  = 1'b1;
                        ecnt_nxt  = '0;
                    end
                end
                S_ARM: begin
                    if (clk_4f_en) begin
                        state_nxt = S_P90;
                        cnt_nxt   = {1'b0, t90_e};
                        bri_nxt   = {f90_s, ff_s, ph90_s, 1'b0, 1'b1};
                    end
                end
                S_P90: begin
                    if (clk_4f_en) begin
                        if (!last) begin
                            cnt_nxt = cnt - 1'b1;
                        end else if (echo_num_s == '0) begin
                            state_nxt = S_DONE;
                            bri_nxt   = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_TAU1;
                            cnt_nxt   = {1'b0, tau_e};
                            bri_nxt   = '0;
                        end
                    end
                end
                S_TAU1: begin
                    if (clk_4f_en) begin
                        if (!last) begin
                            cnt_nxt = cnt - 1'b1;
                        end else begin
                            state_nxt = S_P180;
                            cnt_nxt   = {1'b0, t180_e};
                            bri_nxt   = {1'b0, ff_s, ph_first, 1'b1, 1'b1};
                        end
                    end
                end
                S_P180: begin
                    if (clk_4f_en) begin
                        if (!last) begin
                            cnt_nxt = cnt - 1'b1;
                        end else begin
                            state_nxt = S_ECHO;
                            cnt_nxt   = {tau_e, 1'b0};
                            bri_nxt   = '0;
                            win_nxt   = 1'b1;
                        end
                    end
                end
                S_ECHO: begin
                    if (clk_4f_en) begin
                        if (!last) begin
                            cnt_nxt = cnt - 1'b1;
                        end else begin
                            win_nxt  = 1'b0;
                            ecnt_nxt = ecnt_inc;
                            if (ecnt_inc == echo_num_s) begin
                                state_nxt = S_DONE;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt = S_P180;
                                cnt_nxt   = {1'b0, t180_e};
                                bri_nxt   = {1'b0, ff_s, ph_next, 1'b1, 1'b1};
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    bri_nxt   = '0;
                    win_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule
